// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data RAM between
// the CPU load/store stage and a DMA/debug loader.
module data_ram_arbiter #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ack,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [DATA_WIDTH-1:0] dma_wdata,
   output logic                  dma_ack,
   output logic [DATA_WIDTH-1:0] dma_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   state_t                state;
   state_t                state_next;
   logic                  owner;
   logic                  last_grant;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] dma_rdata_q;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  cpu_elig;
   logic                  dma_elig;
   logic                  grant;
   logic                  winner;

   // A requester being acked this cycle is not eligible; its req is ignored.
   always_comb begin
      cpu_elig = cpu_req & ~((state == RESP) & (owner == OWN_CPU));
      dma_elig = dma_req & ~((state == RESP) & (owner == OWN_DMA));
      grant    = ((state == IDLE) | (state == RESP)) & (cpu_elig | dma_elig);
      winner   = (cpu_elig & dma_elig) ? ~last_grant : dma_elig;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: each combinational block assigns defaults first so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = grant ? ACCESS : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         owner       <= OWN_CPU;
         last_grant  <= OWN_DMA;
         we_q        <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         if (grant) begin
            owner      <= winner;
            last_grant <= winner;
            we_q       <= (winner == OWN_DMA) ? dma_we    : cpu_we;
            ram_addr   <= (winner == OWN_DMA) ? dma_addr  : cpu_addr;
            ram_wdata  <= (winner == OWN_DMA) ? dma_wdata : cpu_wdata;
         end
         if (state == RESP) begin
            if (owner == OWN_CPU) cpu_rdata_q <= resp_data;
            else                  dma_rdata_q <= resp_data;
         end
      end
   end

   // RAM read data arrives in RESP, so the ack cycle forwards it and the
   // holding register keeps it until the next ack to the same requester.
   always_comb begin
      busy      = (state != IDLE);
      ram_en    = (state == ACCESS);
      ram_we    = ram_en & we_q;
      cpu_ack   = (state == RESP) & (owner == OWN_CPU);
      dma_ack   = (state == RESP) & (owner == OWN_DMA);
      resp_data = we_q ? '0 : ram_rdata;
      cpu_rdata = cpu_ack ? resp_data : cpu_rdata_q;
      dma_rdata = dma_ack ? resp_data : dma_rdata_q;
      cpu_stall = cpu_req & ~cpu_ack;
   end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a synchronous-read RAM model.
module tb_data_ram_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [63:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic        cpu_ack, cpu_stall, dma_ack;
   logic [63:0] cpu_rdata, dma_rdata;
   logic        ram_en, ram_we, busy;
   logic [63:0] ram_addr, ram_wdata;
   logic [63:0] ram_rdata = '0;
   logic [63:0] mem [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   data_ram_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr[7:0]];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one cycle; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 64'hDEAD_BEEF;
      mem[8'h30] = 64'hAA;
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      step(); step();

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_dma_ack", dma_ack, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_dma_rdata", dma_rdata, 0);
      check("rst_stall_lo", cpu_stall, 0);
      cpu_req = 1; #1;
      check("rst_stall_hi", cpu_stall, 1);
      cpu_req = 0;
      reset = 0;

      // CPU read of 0x10: ram_en in cycle 1, ack in cycle 2
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10; #1;
      check("rd_stall_c0", cpu_stall, 1);
      step();
      check("rd_ram_en_c1", ram_en, 1);
      check("rd_ram_we_c1", ram_we, 0);
      check("rd_ram_addr_c1", ram_addr, 64'h10);
      check("rd_ack_c1", cpu_ack, 0);
      check("rd_stall_c1", cpu_stall, 1);
      check("rd_busy_c1", busy, 1);
      step();
      check("rd_ack_c2", cpu_ack, 1);
      check("rd_rdata_c2", cpu_rdata, 64'hDEAD_BEEF);
      check("rd_stall_c2", cpu_stall, 0);
      check("rd_ram_en_c2", ram_en, 0);
      cpu_req = 0;
      step();
      check("rd_ack_c3", cpu_ack, 0);
      check("rd_hold_c3", cpu_rdata, 64'hDEAD_BEEF);
      check("rd_busy_c3", busy, 0);
      check("rd_addr_hold_c3", ram_addr, 64'h10);

      // DMA write 0x1234 to 0x20, then CPU read back (queued in DMA's RESP)
      dma_req = 1; dma_we = 1; dma_addr = 64'h20; dma_wdata = 64'h1234;
      step();
      check("dw_ram_en", ram_en, 1);
      check("dw_ram_we", ram_we, 1);
      check("dw_ram_addr", ram_addr, 64'h20);
      check("dw_ram_wdata", ram_wdata, 64'h1234);
      step();
      check("dw_dma_ack", dma_ack, 1);
      check("dw_dma_rdata", dma_rdata, 0);
      check("dw_cpu_ack", cpu_ack, 0);
      dma_req = 0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h20;
      step();
      check("dwr_ram_en", ram_en, 1);
      check("dwr_ram_we", ram_we, 0);
      check("dwr_ram_addr", ram_addr, 64'h20);
      check("dwr_dma_ack_clr", dma_ack, 0);
      step();
      check("dwr_cpu_ack", cpu_ack, 1);
      check("dwr_cpu_rdata", cpu_rdata, 64'h1234);
      cpu_req = 0;
      step();

      // Both requesting from reset: CPU, DMA, CPU, DMA; one access per 2 cycles
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
      dma_req = 1; dma_we = 0; dma_addr = 64'h20;
      for (int c = 1; c <= 8; c++) begin
         step();
         check($sformatf("rr_ram_en_c%0d", c), ram_en, (c % 2) == 1);
         check($sformatf("rr_cpu_ack_c%0d", c), cpu_ack, (c == 2) || (c == 6));
         check($sformatf("rr_dma_ack_c%0d", c), dma_ack, (c == 4) || (c == 8));
         if (c == 2) check("rr_cpu_rdata", cpu_rdata, 64'hDEAD_BEEF);
         if (c == 4) check("rr_dma_rdata", dma_rdata, 64'h1234);
         if (c == 5) check("rr_ram_addr_c5", ram_addr, 64'h10);
         if (c == 7) check("rr_ram_addr_c7", ram_addr, 64'h20);
      end
      cpu_req = 0; dma_req = 0;
      step();
      check("rr_idle", busy, 0);

      // Single requester streaming: acks at 2, 5, 8; idle at 3, 6
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
      for (int c = 1; c <= 8; c++) begin
         step();
         check($sformatf("st_ack_c%0d", c), cpu_ack, (c % 3) == 2);
         check($sformatf("st_busy_c%0d", c), busy, (c % 3) != 0);
      end
      cpu_req = 0;
      step();

      // Reset while in ACCESS drops the access; re-issued request completes
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
      step();
      check("ra_ram_en_c1", ram_en, 1);
      reset = 1;
      step();
      check("ra_cpu_ack_c2", cpu_ack, 0);
      check("ra_busy_c2", busy, 0);
      check("ra_ram_en_c2", ram_en, 0);
      check("ra_ram_addr_c2", ram_addr, 0);
      check("ra_cpu_rdata_c2", cpu_rdata, 0);
      check("ra_dma_rdata_c2", dma_rdata, 0);
      check("ra_stall_c2", cpu_stall, 1);
      reset = 0;
      step();
      check("ra_ram_en_c3", ram_en, 1);
      step();
      check("ra_cpu_ack_c4", cpu_ack, 1);
      check("ra_cpu_rdata_c4", cpu_rdata, 64'hDEAD_BEEF);
      cpu_req = 0;
      step();

      // CPU read of 0xAA stays in cpu_rdata across DMA write and read
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h30;
      step(); step();
      check("iso_cpu_ack", cpu_ack, 1);
      check("iso_cpu_rdata", cpu_rdata, 64'hAA);
      cpu_req = 0;
      step();
      dma_req = 1; dma_we = 1; dma_addr = 64'h40; dma_wdata = 64'h55;
      step(); step();
      check("iso_dw_ack", dma_ack, 1);
      check("iso_dw_dma_rdata", dma_rdata, 0);
      check("iso_dw_cpu_rdata", cpu_rdata, 64'hAA);
      dma_we = 0;
      step();
      check("iso_ignored_busy", busy, 0);
      step(); step();
      check("iso_dr_ack", dma_ack, 1);
      check("iso_dr_dma_rdata", dma_rdata, 64'h55);
      check("iso_dr_cpu_rdata", cpu_rdata, 64'hAA);
      dma_req = 0;
      step();

      // Request dropped after grant still completes with an ack
      cpu_req = 1; cpu_we = 0; cpu_addr = 64'h10;
      step();
      cpu_req = 0; #1;
      check("drop_stall", cpu_stall, 0);
      step();
      check("drop_ack", cpu_ack, 1);
      check("drop_rdata", cpu_rdata, 64'hDEAD_BEEF);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
